mips_datapath_memory_arbiter: RTL and testbench
===============================================

# mips_datapath_memory_arbiter

Two-port arbiter in front of the data-memory byte-addressable memory. It lets the pipeline memory stage share that memory with an external requester, such as a program loader, debug probe or DMA. The CPU has priority; the external port uses a req/ack handshake. A starvation counter bounds how long the external port waits. When the external port wins a cycle the arbiter raises `cpuStall`, so the pipeline holds the memory stage.

## Interface

Parameters:
- `ADDR_L`, 64: memory depth in 32-bit words; must match the memory instance.
- `ADDR_W`, `Util_Math_log2(ADDR_L)`: word-address width (derived).
- `STARVE_L`, 4: maximum consecutive CPU wins while `extReq` is pending; range 1..255.

Ports (name, direction, width, meaning):
- `ctrl`, input, `Data_Control_Control_T`: clock/reset bundle.
  - One clock; the block uses the rising edge.
  - Reset is synchronous and active-high.
  - The block does not invert `ctrl`.
- `cpuReq`, input, 1: memory stage has a load or store this cycle.
- `cpuWren`, input, 1: CPU access is a store.
- `cpuAddr`, input, 32: CPU byte address (ALU result).
- `cpuData`, input, 32: CPU store data (register port 2).
- `cpuBytes`, input, 4: CPU byte enables.
- `cpuOut`, output, 32: read data to the memory stage; equals `memOut` in every cycle.
- `cpuStall`, output, 1: memory stage must hold.
- `extReq`, input, 1: external request; a level held until `extAck`.
- `extWren`, input, 1: external access is a write.
- `extAddr`, input, 32: external byte address.
- `extData`, input, 32: external write data.
- `extBytes`, input, 4: external byte enables.
- `extAck`, output, 1: one-cycle completion pulse.
- `extOut`, output, 32: registered external read data; valid while `extAck`=1, held afterwards.
- `grantExt`, output, 1: memory is driven by the external port this cycle.
- `memAddr`, output, `ADDR_W+2`: byte address to memory; low bits of the selected address.
- `memData`, output, 32: write data to memory.
- `memBytes`, output, 4: byte enables to memory.
- `memWren`, output, 1: memory write enable.
- `memOut`, input, 32: memory read data. It is valid in the same cycle as `memAddr` because the memory is clocked on the inverted edge.

## Operation

- FSM has two states: `ARB` and `ACK`. Reset state is `ARB`.
- **ARB state:**
  - `grantExt` = `extReq & (!cpuReq | starveCnt == STARVE_L)`; combinational from registered state and inputs.
  - Next state is `ACK` if `grantExt`, else `ARB`.
- **ACK state:**
  - `grantExt`=0 and the CPU is always granted.
  - `extReq` is ignored (the requester is still holding it).
  - Next state is always `ARB`.
- **Memory mux:**
  - When `grantExt`=1, the `mem*` outputs take the `ext*` fields.
  - Otherwise they take the `cpu*` fields.
  - `memWren` = granted requester's wren AND that requester's req AND !reset. No write occurs when nothing is requested.
- **CPU stall:** `cpuStall` = `cpuReq & grantExt`.
- **extOut register:** on a cycle with `grantExt` and `!extWren`, `extOut` <= `memOut`. On an external write, `extOut` holds its previous value.
- **extAck:** registered. It is 1 exactly in the `ACK` state, i.e. the cycle after the grant.
- **starveCnt:** `ceil(log2(STARVE_L+1))` bits, saturating.
  - In `ARB` with `extReq & cpuReq & !grantExt`: increments, saturating at `STARVE_L`.
  - On `grantExt`, or in `ARB` with `extReq`=0: cleared to 0.
  - In `ACK`: holds.
- **Address range:** out-of-range high address bits are silently dropped; the block does no bounds checking.

## Timing

- **Reset values:**
  - State `ARB`, `starveCnt`=0.
  - `extAck`=0, `extOut`=0.
  - `memWren`=0 while reset is high.
  - During reset the combinational outputs still follow the rules above, except `memWren`.
- **External latency:**
  - Ungrained by the CPU: grant in the cycle `extReq` rises; `extAck` the next cycle.
  - Worst case under continuous `cpuReq`: grant `STARVE_L` cycles after `extReq` rises, ack `STARVE_L+1` cycles after.
- **Throughput:** with `extReq` held continuously, the external port gets at most one access per 2 cycles. The requester must drop or re-issue `extReq` on the cycle after `extAck` for a new access.
- **CPU access:** zero added latency when granted. Each external grant costs the CPU at most one stall cycle.
- **Simultaneous events:**
  - `extReq` and `cpuReq` rise together: CPU wins until the counter saturates.
  - `extReq` dropped before grant: counter clears, no ack.
- **Reset asserted in ACK:** next cycle state is `ARB` and `extAck`=0. The pending external access is considered lost; the requester retries.

## Test plan

- **Reset:** hold reset 2 cycles with `extReq`=1, `cpuReq`=1.
  - `memWren`=0, `extAck`=0, `extOut`=0.
  - After release, state `ARB` and `starveCnt`=0.
- **External read, idle CPU:** preload word 2 = 0xDEADBEEF. Pulse `extReq` with `extAddr`=0x8, `extWren`=0.
  - `grantExt`=1 in cycle 0.
  - Cycle 1: `extAck`=1, `extOut`=0xDEADBEEF, `cpuStall`=0 throughout.
- **Contention, `STARVE_L`=4:** `cpuReq`=1 continuously; `extReq` rises at cycle 0.
  - CPU granted cycles 0-3.
  - Cycle 4: `grantExt`=1 and `cpuStall`=1.
  - Cycle 5: `extAck`=1, `cpuStall`=0.
- **External byte write, then CPU read:** `extWren`=1, `extBytes`=0001, `extData`=0x000000AB, address 0x4 over word 0x11223344. Then a CPU read of 0x4.
  - `cpuOut`=0x112233AB.
  - `extOut` unchanged by the write.
- **Back-to-back external requests:** `extReq` held high for 6 cycles with the CPU idle.
  - `grantExt` in cycles 0, 2, 4.
  - `extAck` in cycles 1, 3, 5.
- **Reset in ACK:** assert reset in the `ACK` cycle.
  - Next cycle `extAck`=0, state `ARB`, no memory write.

Source files
------------

// File: rtl/mips_datapath_memory_arbiter.sv
// Data-memory arbiter: the CPU memory stage has priority, an external req/ack
// port is guaranteed the memory after at most STARVE_L consecutive CPU wins.
package mips_datapath_memory_arbiter_pkg;
  typedef struct packed {
    logic clk;
    logic rst;
  } Data_Control_Control_T;

  // Ceiling log2, usable in parameter expressions.
  function automatic int Util_Math_log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction
endpackage

module mips_datapath_memory_arbiter
  import mips_datapath_memory_arbiter_pkg::*;
#(
  parameter int ADDR_L   = 64,
  parameter int ADDR_W   = Util_Math_log2(ADDR_L),
  parameter int STARVE_L = 4
) (
  input  Data_Control_Control_T ctrl,
  input  logic                  cpuReq,
  input  logic                  cpuWren,
  input  logic [31:0]           cpuAddr,
  input  logic [31:0]           cpuData,
  input  logic [3:0]            cpuBytes,
  output logic [31:0]           cpuOut,
  output logic                  cpuStall,
  input  logic                  extReq,
  input  logic                  extWren,
  input  logic [31:0]           extAddr,
  input  logic [31:0]           extData,
  input  logic [3:0]            extBytes,
  output logic                  extAck,
  output logic [31:0]           extOut,
  output logic                  grantExt,
  output logic [ADDR_W+1:0]     memAddr,
  output logic [31:0]           memData,
  output logic [3:0]            memBytes,
  output logic                  memWren,
  input  logic [31:0]           memOut
);
  localparam int STARVE_W = Util_Math_log2(STARVE_L + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_L);

  typedef enum logic {
    ARB = 1'b0,
    ACK = 1'b1
  } state_t;

  logic clk;
  logic srst;
  assign clk  = ctrl.clk;
  assign srst = ctrl.rst;

  state_t              state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]         ext_out_q, ext_out_d;
  logic                grant;
  logic                starved;
  logic                sel_wren;

  // Address bits above the memory depth are dropped on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpuAddr[31:ADDR_W+2], extAddr[31:ADDR_W+2]};

  assign starved = (starve_cnt_q == STARVE_MAX);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ext_out_d    = ext_out_q;
    grant        = 1'b0;
    case (state_q)
      ARB: begin
        grant   = extReq & (~cpuReq | starved);
        state_d = grant ? ACK : ARB;
        if (grant || !extReq) begin
          starve_cnt_d = '0;
        end else if (!starved) begin
          starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
      end
      // Requester still holds extReq here; it is ignored and the CPU owns memory.
      ACK: state_d = ARB;
      default: state_d = ARB;
    endcase
    if (grant && !extWren) begin
      ext_out_d = memOut;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
      ext_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ext_out_q    <= ext_out_d;
    end
  end

  always_comb begin
    if (grant) begin
      memAddr  = extAddr[ADDR_W+1:0];
      memData  = extData;
      memBytes = extBytes;
      sel_wren = extWren & extReq;
    end else begin
      memAddr  = cpuAddr[ADDR_W+1:0];
      memData  = cpuData;
      memBytes = cpuBytes;
      sel_wren = cpuWren & cpuReq;
    end
    memWren = sel_wren & ~srst;
  end

  assign grantExt = grant;
  assign cpuStall = cpuReq & grant;
  assign cpuOut   = memOut;
  assign extAck   = (state_q == ACK);
  assign extOut   = ext_out_q;
endmodule

// File: tb/tb_mips_datapath_memory_arbiter.sv
// Randomized and directed bench for the data-memory arbiter, checked against a
// cycle-level behavioural model with its own shadow memory.
module tb_mips_datapath_memory_arbiter;
  import mips_datapath_memory_arbiter_pkg::*;

  localparam int ADDR_L   = 64;
  localparam int ADDR_W   = 6;
  localparam int AW       = ADDR_W + 2;
  localparam int STARVE_L = 4;

  typedef struct packed {
    logic        rst;
    logic        cr;
    logic        cw;
    logic [31:0] ca;
    logic [31:0] cd;
    logic [3:0]  cb;
    logic        er;
    logic        ew;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  eb;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  Data_Control_Control_T ctrl;
  logic        cpuReq, cpuWren, extReq, extWren;
  logic [31:0] cpuAddr, cpuData, extAddr, extData;
  logic [3:0]  cpuBytes, extBytes;
  logic [31:0] cpuOut, extOut, memData, memOut;
  logic        cpuStall, extAck, grantExt, memWren;
  logic [AW-1:0] memAddr;
  logic [3:0]  memBytes;

  always #5 clk = ~clk;
  assign ctrl = {clk, rst};

  mips_datapath_memory_arbiter #(
    .ADDR_L(ADDR_L), .ADDR_W(ADDR_W), .STARVE_L(STARVE_L)
  ) dut (
    .ctrl(ctrl),
    .cpuReq(cpuReq), .cpuWren(cpuWren), .cpuAddr(cpuAddr), .cpuData(cpuData),
    .cpuBytes(cpuBytes), .cpuOut(cpuOut), .cpuStall(cpuStall),
    .extReq(extReq), .extWren(extWren), .extAddr(extAddr), .extData(extData),
    .extBytes(extBytes), .extAck(extAck), .extOut(extOut), .grantExt(grantExt),
    .memAddr(memAddr), .memData(memData), .memBytes(memBytes), .memWren(memWren),
    .memOut(memOut)
  );

  // Memory environment: written on the falling edge, read data available same cycle.
  logic [31:0] mem [ADDR_L];
  initial begin
    for (int i = 0; i < ADDR_L; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      if (memWren) begin
        for (int b = 0; b < 4; b++) begin
          if (memBytes[b]) mem[memAddr[AW-1:2]][8*b +: 8] = memData[8*b +: 8];
        end
      end
    end
  end
  assign memOut = mem[memAddr[AW-1:2]];

  // Reference model state.
  logic [31:0] ref_mem [ADDR_L];
  bit          m_ack_owed;
  int          m_cpu_wins;
  logic [31:0] m_ext_out;
  bit          last_ack;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_cycle(input stim_t s);
    bit          eg;
    bit          ewren;
    logic [AW-1:0] eaddr;
    logic [31:0] edata;
    logic [3:0]  ebytes;
    int          widx;
    @(posedge clk);
    #1;
    cyc++;
    rst = s.rst;
    cpuReq = s.cr; cpuWren = s.cw; cpuAddr = s.ca; cpuData = s.cd; cpuBytes = s.cb;
    extReq = s.er; extWren = s.ew; extAddr = s.ea; extData = s.ed; extBytes = s.eb;
    #3;
    // External wins when nothing is owed, it asks, and the CPU is absent or has won STARVE_L times.
    eg     = !m_ack_owed && s.er && (!s.cr || m_cpu_wins >= STARVE_L);
    eaddr  = eg ? s.ea[AW-1:0] : s.ca[AW-1:0];
    edata  = eg ? s.ed : s.cd;
    ebytes = eg ? s.eb : s.cb;
    ewren  = !s.rst && (eg ? (s.ew && s.er) : (s.cw && s.cr));
    widx   = int'(eaddr[AW-1:2]);
    check_eq("grantExt", 32'(grantExt), 32'(eg));
    check_eq("cpuStall", 32'(cpuStall), 32'(eg && s.cr));
    check_eq("extAck", 32'(extAck), 32'(m_ack_owed));
    check_eq("extOut", extOut, m_ext_out);
    check_eq("memWren", 32'(memWren), 32'(ewren));
    check_eq("memAddr", 32'(memAddr), 32'(eaddr));
    check_eq("memData", memData, edata);
    check_eq("memBytes", 32'(memBytes), 32'(ebytes));
    check_eq("cpuOut", cpuOut, ref_mem[widx]);
    last_ack = m_ack_owed;
    if (ewren) begin
      for (int b = 0; b < 4; b++) begin
        if (ebytes[b]) ref_mem[widx][8*b +: 8] = edata[8*b +: 8];
      end
    end
    if (s.rst) begin
      m_ack_owed = 0;
      m_cpu_wins = 0;
      m_ext_out  = '0;
    end else begin
      if (eg && !s.ew) m_ext_out = ref_mem[widx];
      if (!m_ack_owed) begin
        if (eg || !s.er) m_cpu_wins = 0;
        else if (m_cpu_wins < STARVE_L) m_cpu_wins++;
      end
      m_ack_owed = eg;
    end
  endtask

  function automatic stim_t ext_op(input bit wr, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [3:0] be);
    stim_t s;
    s = '0;
    s.er = 1'b1; s.ew = wr; s.ea = addr; s.ed = data; s.eb = be;
    return s;
  endfunction

  initial begin
    stim_t s;
    stim_t ext_s;
    for (int i = 0; i < ADDR_L; i++) ref_mem[i] = '0;
    m_ack_owed = 0; m_cpu_wins = 0; m_ext_out = '0; last_ack = 0;

    // Reset held with both requesters active.
    rst = 1'b1;
    cpuReq = 1'b1; cpuWren = 1'b1; cpuAddr = 32'h10; cpuData = 32'h5555_AAAA; cpuBytes = 4'hF;
    extReq = 1'b1; extWren = 1'b1; extAddr = 32'h14; extData = 32'h1234_5678; extBytes = 4'hF;
    #4;
    check_eq("rst_wren_first", 32'(memWren), 32'd0);
    s = ext_op(1'b1, 32'h14, 32'h1234_5678, 4'hF);
    s.rst = 1'b1; s.cr = 1'b1; s.cw = 1'b1; s.ca = 32'h10; s.cd = 32'h5555_AAAA; s.cb = 4'hF;
    drive_cycle(s);
    drive_cycle(s);
    check_eq("rst_extOut", extOut, 32'h0);
    drive_cycle('0);

    // Preload word 2 and word 1 through the external port.
    drive_cycle(ext_op(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF));
    drive_cycle(ext_op(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF));
    drive_cycle('0);
    drive_cycle(ext_op(1'b1, 32'h4, 32'h1122_3344, 4'hF));
    drive_cycle(ext_op(1'b1, 32'h4, 32'h1122_3344, 4'hF));
    drive_cycle('0);

    // External read with an idle CPU.
    drive_cycle(ext_op(1'b0, 32'h8, 32'h0, 4'hF));
    check_eq("rd_grant", 32'(grantExt), 32'd1);
    check_eq("rd_stall0", 32'(cpuStall), 32'd0);
    drive_cycle(ext_op(1'b0, 32'h8, 32'h0, 4'hF));
    check_eq("rd_ack", 32'(extAck), 32'd1);
    check_eq("rd_data", extOut, 32'hDEAD_BEEF);
    check_eq("rd_stall1", 32'(cpuStall), 32'd0);
    drive_cycle('0);

    // Contention: CPU wins four times, then the external write is granted.
    for (int c = 0; c < 6; c++) begin
      s = ext_op(1'b1, 32'h28, $urandom, 4'hF);
      s.cr = 1'b1; s.ca = 32'h8;
      drive_cycle(s);
      check_eq("cont_grant", 32'(grantExt), 32'(c == 4));
      check_eq("cont_stall", 32'(cpuStall), 32'(c == 4));
      check_eq("cont_ack", 32'(extAck), 32'(c == 5));
    end
    drive_cycle('0);

    // External byte write, then CPU read of the same word.
    drive_cycle(ext_op(1'b1, 32'h4, 32'h0000_00AB, 4'b0001));
    drive_cycle(ext_op(1'b1, 32'h4, 32'h0000_00AB, 4'b0001));
    s = '0; s.cr = 1'b1; s.ca = 32'h4;
    drive_cycle(s);
    check_eq("bw_cpuOut", cpuOut, 32'h1122_33AB);
    check_eq("bw_extOut", extOut, 32'hDEAD_BEEF);
    drive_cycle('0);

    // extReq held for six cycles: one access every two cycles.
    for (int c = 0; c < 6; c++) begin
      drive_cycle(ext_op(1'b0, 32'h8, 32'h0, 4'hF));
      check_eq("b2b_grant", 32'(grantExt), 32'((c % 2) == 0));
      check_eq("b2b_ack", 32'(extAck), 32'((c % 2) == 1));
    end
    drive_cycle('0);

    // Reset asserted during the ACK cycle, with a CPU store pending.
    drive_cycle(ext_op(1'b0, 32'h4, 32'h0, 4'hF));
    s = ext_op(1'b0, 32'h4, 32'h0, 4'hF);
    s.rst = 1'b1; s.cr = 1'b1; s.cw = 1'b1; s.ca = 32'h8; s.cd = 32'h0; s.cb = 4'hF;
    drive_cycle(s);
    check_eq("rack_wren", 32'(memWren), 32'd0);
    drive_cycle(ext_op(1'b0, 32'h8, 32'h0, 4'hF));
    check_eq("rack_ack", 32'(extAck), 32'd0);
    check_eq("rack_grant", 32'(grantExt), 32'd1);
    drive_cycle(ext_op(1'b0, 32'h8, 32'h0, 4'hF));
    check_eq("rack_data", extOut, 32'hDEAD_BEEF);
    drive_cycle('0);

    // Random traffic; the external requester mostly follows the level protocol.
    ext_s = '0;
    for (int k = 0; k < 500; k++) begin
      if (last_ack || (ext_s.er && $urandom_range(0, 15) == 0)) begin
        ext_s.er = 1'b0;
      end else if (!ext_s.er && $urandom_range(0, 1) == 1) begin
        ext_s = ext_op(1'($urandom), $urandom, $urandom, 4'($urandom));
      end
      s = ext_s;
      s.rst = ($urandom_range(0, 59) == 0);
      s.cr  = ($urandom_range(0, 9) < 7);
      s.cw  = 1'($urandom);
      s.ca  = $urandom;
      s.cd  = $urandom;
      s.cb  = 4'($urandom);
      drive_cycle(s);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
